// File: rtl/ddc_pack_pkg.sv
// Shared types and constants for the DDC sample-to-RAM packer.
package ddc_pack_pkg;

    // Default address width of one ping-pong bank (depth = 2^BANK_AW words).
    localparam int unsigned DEF_BANK_AW = 13;

    localparam int unsigned SAMPLE_W  = 16;
    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned WORD_W    = SAMPLE_W * NUM_LANES;
    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned PRI_W     = 16;

    // Capture state machine.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CAPT = 1'b1
    } state_t;

    // 16-bit slot of each sample inside the RAM word; slot 7 is bits [127:112].
    localparam int unsigned LANE_1_I = 7;
    localparam int unsigned LANE_1_Q = 6;
    localparam int unsigned LANE_2_I = 5;
    localparam int unsigned LANE_2_Q = 4;
    localparam int unsigned LANE_3_I = 3;
    localparam int unsigned LANE_3_Q = 2;
    localparam int unsigned LANE_4_I = 1;
    localparam int unsigned LANE_4_Q = 0;

    typedef logic [NUM_LANES-1:0][SAMPLE_W-1:0] lanes_t;

    // One write request from the capture control to the word packer.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        lanes_t            lanes;
    } wr_req_t;

endpackage : ddc_pack_pkg

// File: rtl/ddc_word_packer.sv
// Registers the eight lane samples into one 128-bit RAM word with its strobe.
module ddc_word_packer
    import ddc_pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  wr_req_t           i_req,
    output logic              o_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [WORD_W-1:0] o_din
);

    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_din;

    // Strobe follows the request every cycle; address/data only move on writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            r_wr <= i_req.wr;
            if (i_req.wr) begin
                r_addr <= i_req.addr;
                r_din  <= WORD_W'(i_req.lanes);
            end
        end
    end

    assign o_wr   = r_wr;
    assign o_addr = r_addr;
    assign o_din  = r_din;

endmodule : ddc_word_packer

// File: rtl/ddc_ram_pack_v1.sv
// Captures DDC I/Q samples per PRI into ping-pong RAM banks and reports each
// completed frame (length, bank, PRI index, overflow). BANK_AW must be <= 13.
module ddc_ram_pack_v1
    import ddc_pack_pkg::*;
#(
    parameter int unsigned BANK_AW = DEF_BANK_AW
) (
    input  logic                pro_clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] data_1_I,
    input  logic [SAMPLE_W-1:0] data_1_Q,
    input  logic [SAMPLE_W-1:0] data_2_I,
    input  logic [SAMPLE_W-1:0] data_2_Q,
    input  logic [SAMPLE_W-1:0] data_3_I,
    input  logic [SAMPLE_W-1:0] data_3_Q,
    input  logic [SAMPLE_W-1:0] data_4_I,
    input  logic [SAMPLE_W-1:0] data_4_Q,
    input  logic                data_valid,
    input  logic                data_pri,
    input  logic                data_cpi,
    output logic                data_ram_wr,
    output logic [ADDR_W-1:0]   data_ram_addra,
    output logic [WORD_W-1:0]   data_ram_din,
    output logic [LEN_W-1:0]    data_length,
    output logic                rd_bank,
    output logic                frame_ready,
    output logic [PRI_W-1:0]    pri_index,
    output logic                overflow
);

    localparam int unsigned CNT_W = BANK_AW + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {BANK_AW{1'b0}}};

    state_t             r_state;
    state_t             w_next_state;

    logic               r_wr_bank;
    logic [CNT_W-1:0]   r_wr_cnt;
    logic [PRI_W-1:0]   r_pri_cnt;
    logic               r_ovf_sticky;

    logic [LEN_W-1:0]   r_data_length;
    logic               r_rd_bank;
    logic               r_frame_ready;
    logic [PRI_W-1:0]   r_pri_index;
    logic               r_overflow;

    logic               w_start;
    logic               w_close;
    logic               w_accept;
    logic               w_drop;
    logic               w_cpi_clr;

    logic               w_tgt_bank;
    logic [BANK_AW-1:0] w_tgt_off;
    lanes_t             w_lanes;
    wr_req_t            w_req;

    // State register.
    always_ff @(posedge pro_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and per-cycle control decisions.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_close      = 1'b0;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        w_cpi_clr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && data_pri) begin
                    w_next_state = ST_CAPT;
                    w_start      = 1'b1;
                end
            end
            ST_CAPT: begin
                if (!enable) begin
                    // Abandon the partial frame silently.
                    w_next_state = ST_IDLE;
                end else begin
                    w_close   = data_pri;
                    w_cpi_clr = data_cpi && !data_pri;
                    if (data_valid) begin
                        // A sample coinciding with data_pri opens the new frame.
                        if (data_pri || (r_wr_cnt != DEPTH)) begin
                            w_accept = 1'b1;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Write-pointer, PRI counter and frame-result registers.
    always_ff @(posedge pro_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank     <= 1'b0;
            r_wr_cnt      <= '0;
            r_pri_cnt     <= '0;
            r_ovf_sticky  <= 1'b0;
            r_data_length <= '0;
            r_rd_bank     <= 1'b0;
            r_frame_ready <= 1'b0;
            r_pri_index   <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_frame_ready <= 1'b0;
            if (w_start) begin
                r_wr_bank    <= 1'b0;
                r_wr_cnt     <= '0;
                r_pri_cnt    <= '0;
                r_ovf_sticky <= 1'b0;
            end else if (w_close) begin
                r_data_length <= LEN_W'(r_wr_cnt);
                r_rd_bank     <= r_wr_bank;
                r_pri_index   <= r_pri_cnt;
                r_overflow    <= r_ovf_sticky;
                r_frame_ready <= 1'b1;
                r_wr_bank     <= ~r_wr_bank;
                r_wr_cnt      <= w_accept ? CNT_W'(1) : '0;
                r_ovf_sticky  <= 1'b0;
                r_pri_cnt     <= data_cpi ? '0 : r_pri_cnt + PRI_W'(1);
            end else begin
                if (w_accept) begin
                    r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                end
                if (w_drop) begin
                    r_ovf_sticky <= 1'b1;
                end
                if (w_cpi_clr) begin
                    r_pri_cnt <= '0;
                end
            end
        end
    end

    // Target slot: a closing cycle writes offset 0 of the bank being switched to.
    always_comb begin
        w_tgt_bank = r_wr_bank;
        w_tgt_off  = r_wr_cnt[BANK_AW-1:0];
        if (w_close) begin
            w_tgt_bank = ~r_wr_bank;
            w_tgt_off  = '0;
        end
    end

    // Place each sample in its RAM-word slot.
    always_comb begin
        w_lanes           = '0;
        w_lanes[LANE_1_I] = data_1_I;
        w_lanes[LANE_1_Q] = data_1_Q;
        w_lanes[LANE_2_I] = data_2_I;
        w_lanes[LANE_2_Q] = data_2_Q;
        w_lanes[LANE_3_I] = data_3_I;
        w_lanes[LANE_3_Q] = data_3_Q;
        w_lanes[LANE_4_I] = data_4_I;
        w_lanes[LANE_4_Q] = data_4_Q;
    end

    // Write request handed to the packer; upper address bits stay zero.
    always_comb begin
        w_req       = '0;
        w_req.wr    = w_accept;
        w_req.addr  = ADDR_W'({w_tgt_bank, w_tgt_off});
        w_req.lanes = w_lanes;
    end

    ddc_word_packer u_packer (
        .clk    (pro_clk),
        .rst_n  (rst_n),
        .i_req  (w_req),
        .o_wr   (data_ram_wr),
        .o_addr (data_ram_addra),
        .o_din  (data_ram_din)
    );

    assign data_length = r_data_length;
    assign rd_bank     = r_rd_bank;
    assign frame_ready = r_frame_ready;
    assign pri_index   = r_pri_index;
    assign overflow    = r_overflow;

endmodule : ddc_ram_pack_v1

// File: tb/tb_ddc_ram_pack_v1.sv
// Self-checking bench for ddc_ram_pack_v1: directed scenarios plus random traffic
// compared against a frame-level behavioural model.
module tb_ddc_ram_pack_v1;

    localparam int DEPTH = 8192;

    logic          pro_clk = 1'b0;
    logic          rst_n;
    logic          en, pri, cpi, val;
    logic [15:0]   smp [8];

    logic          data_ram_wr;
    logic [13:0]   data_ram_addra;
    logic [127:0]  data_ram_din;
    logic [15:0]   data_length;
    logic          rd_bank;
    logic          frame_ready;
    logic [15:0]   pri_index;
    logic          overflow;

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_wr;
    logic [13:0]   last_addr;

    // Behavioural model state
    bit            m_capt;
    bit            m_bank;
    int            m_cnt;
    logic [15:0]   m_pri;
    bit            m_ovf;

    // Expected outputs after the next edge
    bit            e_wr;
    logic [13:0]   e_addr;
    logic [127:0]  e_din;
    logic [15:0]   e_len;
    bit            e_rdb;
    bit            e_fr;
    logic [15:0]   e_idx;
    bit            e_ovf;

    always #5 pro_clk = ~pro_clk;

    ddc_ram_pack_v1 dut (
        .pro_clk        (pro_clk),
        .rst_n          (rst_n),
        .enable         (en),
        .data_1_I       (smp[0]),
        .data_1_Q       (smp[1]),
        .data_2_I       (smp[2]),
        .data_2_Q       (smp[3]),
        .data_3_I       (smp[4]),
        .data_3_Q       (smp[5]),
        .data_4_I       (smp[6]),
        .data_4_Q       (smp[7]),
        .data_valid     (val),
        .data_pri       (pri),
        .data_cpi       (cpi),
        .data_ram_wr    (data_ram_wr),
        .data_ram_addra (data_ram_addra),
        .data_ram_din   (data_ram_din),
        .data_length    (data_length),
        .rd_bank        (rd_bank),
        .frame_ready    (frame_ready),
        .pri_index      (pri_index),
        .overflow       (overflow)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_capt = 0; m_bank = 0; m_cnt = 0; m_pri = '0; m_ovf = 0;
        e_wr = 0; e_addr = '0; e_din = '0; e_len = '0;
        e_rdb = 0; e_fr = 0; e_idx = '0; e_ovf = 0;
    endtask

    // Frame rules: a PRI pulse closes the running frame first, then any
    // coincident sample is handled as part of the frame just opened.
    task automatic model_tick();
        e_wr = 0;
        e_fr = 0;
        if (!m_capt) begin
            if (en && pri) begin
                m_capt = 1; m_bank = 0; m_cnt = 0; m_pri = '0; m_ovf = 0;
            end
        end else if (!en) begin
            m_capt = 0;
        end else begin
            if (pri) begin
                e_fr  = 1;
                e_len = 16'(m_cnt);
                e_rdb = m_bank;
                e_idx = m_pri;
                e_ovf = m_ovf;
                m_bank = !m_bank;
                m_cnt  = 0;
                m_ovf  = 0;
                m_pri  = cpi ? 16'd0 : m_pri + 16'd1;
            end else if (cpi) begin
                m_pri = '0;
            end
            if (val) begin
                if (m_cnt < DEPTH) begin
                    e_wr   = 1;
                    e_addr = 14'(int'(m_bank) * DEPTH + m_cnt);
                    e_din  = {smp[0], smp[1], smp[2], smp[3], smp[4], smp[5], smp[6], smp[7]};
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    task automatic compare();
        check_eq("wr", 128'(data_ram_wr), 128'(e_wr));
        if (e_wr) begin
            check_eq("addr", 128'(data_ram_addra), 128'(e_addr));
            check_eq("din", data_ram_din, e_din);
        end
        check_eq("frame_ready", 128'(frame_ready), 128'(e_fr));
        check_eq("data_length", 128'(data_length), 128'(e_len));
        check_eq("rd_bank", 128'(rd_bank), 128'(e_rdb));
        check_eq("pri_index", 128'(pri_index), 128'(e_idx));
        check_eq("overflow", 128'(overflow), 128'(e_ovf));
    endtask

    // One clock: predict, clock, compare #1 after the edge, clear pulses.
    task automatic step();
        if (!rst_n) model_reset();
        else model_tick();
        @(posedge pro_clk);
        #1;
        compare();
        if (data_ram_wr) begin
            n_wr++;
            last_addr = data_ram_addra;
        end
        pri = 0; cpi = 0; val = 0;
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) smp[k] = 16'($urandom);
            val = 1;
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; en = 0; pri = 0; cpi = 0; val = 0;
        for (int k = 0; k < 8; k++) smp[k] = '0;
        model_reset();
        n_wr = 0;
        last_addr = '0;
        repeat (3) step();
        rst_n = 1;
        step();

        // 100 beats with a ramp on lane 1_I, then close
        en = 1; pri = 1; step();
        for (int n = 0; n < 100; n++) begin
            smp[0] = 16'(n);
            smp[1] = 16'h1111; smp[2] = 16'h2222; smp[3] = 16'h3333;
            smp[4] = 16'h4444; smp[5] = 16'h5555; smp[6] = 16'h6666; smp[7] = 16'h7777;
            val = 1;
            step();
            if (n == 0) check_eq("d1_first_addr", 128'(data_ram_addra), 128'(0));
        end
        pri = 1; step();
        check_eq("d1_fr", 128'(frame_ready), 128'(1));
        check_eq("d1_len", 128'(data_length), 128'(100));
        check_eq("d1_rdb", 128'(rd_bank), 128'(0));
        val = 1; step();
        check_eq("d1_next_addr", 128'(data_ram_addra), 128'(14'h2000));

        // Coincident PRI and sample: sample starts the new bank at offset 0
        beats(4);
        for (int k = 0; k < 8; k++) smp[k] = 16'($urandom);
        pri = 1; val = 1; step();
        check_eq("d2_len", 128'(data_length), 128'(5));
        check_eq("d2_rdb", 128'(rd_bank), 128'(1));
        check_eq("d2_addr", 128'(data_ram_addra), 128'(14'h0000));
        beats(1);
        pri = 1; step();
        check_eq("d2_len_next", 128'(data_length), 128'(2));

        // Overflow: 8200 beats into one bank
        n_wr = 0;
        beats(8200);
        check_eq("d3_nwr", 128'(n_wr), 128'(8192));
        check_eq("d3_last_off", 128'(last_addr[12:0]), 128'(13'h1FFF));
        pri = 1; step();
        check_eq("d3_len", 128'(data_length), 128'(8192));
        check_eq("d3_ovf", 128'(overflow), 128'(1));
        beats(10);
        pri = 1; step();
        check_eq("d3_len_next", 128'(data_length), 128'(10));
        check_eq("d3_ovf_next", 128'(overflow), 128'(0));

        // CPI restart of the PRI numbering
        beats(2);
        pri = 1; cpi = 1; step();
        for (int k = 0; k < 3; k++) begin
            beats(3);
            pri = 1; step();
            check_eq("d4_pri_index", 128'(pri_index), 128'(k));
        end

        // Asynchronous reset mid-capture
        beats(5);
        #3 rst_n = 0;
        #1;
        check_eq("d5_async_wr", 128'(data_ram_wr), 128'(0));
        check_eq("d5_async_len", 128'(data_length), 128'(0));
        check_eq("d5_async_din", data_ram_din, 128'(0));
        check_eq("d5_async_idx", 128'(pri_index), 128'(0));
        model_reset();
        repeat (3) step();
        rst_n = 1;
        n_wr = 0;
        beats(6);
        check_eq("d5_no_wr", 128'(n_wr), 128'(0));

        // Enable drop mid-PRI
        pri = 1; step();
        beats(3);
        pri = 1; step();
        beats(4);
        en = 0; step();
        en = 1;
        n_wr = 0;
        beats(3);
        check_eq("d6_idle_no_wr", 128'(n_wr), 128'(0));
        check_eq("d6_len_held", 128'(data_length), 128'(3));

        // Random traffic
        for (int c = 0; c < 6000; c++) begin
            en  = ($urandom_range(0, 299) != 0);
            pri = ($urandom_range(0, 39) == 0);
            cpi = pri && ($urandom_range(0, 3) == 0);
            val = ($urandom_range(0, 9) < 7);
            if (!m_capt && pri) val = 0;
            for (int k = 0; k < 8; k++) smp[k] = 16'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ddc_ram_pack_v1

// File: doc/ddc_ram_pack_v1.md
DDC_RAM_PACK_V1 -- requirements
Module: ddc_ram_pack_v1

Interface
REQ-001 Parameter BANK_AW, default 13: address width of one ping-pong bank; bank depth is 2^BANK_AW words.
REQ-002 pro_clk  input  1  the single processing clock; all logic is on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 enable  input  1  capture enable.
REQ-005 data_1_I .. data_4_Q  input  16 each (8 ports)  DDC I/Q samples for four channels.
REQ-006 data_valid  input  1  the eight samples are valid this cycle.
REQ-007 data_pri  input  1  one-cycle PRI-start pulse.
REQ-008 data_cpi  input  1  one-cycle CPI-start pulse; it coincides with data_pri.
REQ-009 data_ram_wr  output  1  dual-port RAM port-A write enable.
REQ-010 data_ram_addra  output  14  RAM port-A address: {bank, word offset}.
REQ-011 data_ram_din  output  128  packed RAM write word.
REQ-012 data_length  output  16  word count of the last completed PRI.
REQ-013 rd_bank  output  1  bank that holds the last completed PRI.
REQ-014 frame_ready  output  1  one-cycle pulse when data_length and rd_bank update.
REQ-015 pri_index  output  16  PRI number within the current CPI for the completed frame.
REQ-016 overflow  output  1  the completed frame exceeded the bank depth.

Function
REQ-017 States SHALL be IDLE and CAPT; reset enters IDLE.
REQ-018 IDLE SHALL move to CAPT on data_pri while enable=1; in that cycle wr_bank<=0, wr_cnt<=0, pri_cnt<=0.
REQ-019 CAPT SHALL return to IDLE when enable=0: the partial frame is discarded, no frame_ready, outputs held.
REQ-020 In CAPT with data_valid=1 and wr_cnt<2^BANK_AW, the write SHALL proceed; one cycle later data_ram_wr=1, data_ram_addra={wr_bank, wr_cnt}, then wr_cnt++.
REQ-021 Packing SHALL be data_ram_din={1_I,1_Q,2_I,2_Q,3_I,3_Q,4_I,4_Q}, with 1_I in bits [127:112].
REQ-022 data_ram_wr SHALL be 0 in every cycle that does not follow an accepted sample.
REQ-023 In CAPT, data_pri SHALL close the frame, with results registered in the next cycle: data_length<=wr_cnt (zero-extended), rd_bank<=wr_bank, pri_index<=pri_cnt, overflow<=ovf_sticky, frame_ready=1.
REQ-024 In the same closing cycle, wr_bank SHALL toggle, wr_cnt<=0 and ovf_sticky<=0.
REQ-025 pri_cnt SHALL increment on each data_pri in CAPT, wrap at 16 bits, and clear to 0 when data_cpi=1.
REQ-026 When data_pri and data_valid coincide, the sample SHALL belong to the new frame: written at offset 0 of the toggled bank, and the new wr_cnt=1.
REQ-027 When data_valid=1 and wr_cnt=2^BANK_AW, the sample SHALL be dropped (no write, wr_cnt saturates) and ovf_sticky<=1.
REQ-028 An empty PRI (no valid samples) SHALL still produce frame_ready, with data_length=0.
REQ-029 Write latency from data_valid to data_ram_wr SHALL be exactly 1 cycle; frame_ready SHALL come 1 cycle after data_pri.
REQ-030 Address bits above BANK_AW+1 SHALL be 0.

Reset
REQ-031 While rst_n=0, every output and internal register SHALL be 0 and the state SHALL be IDLE, independent of pro_clk.
REQ-032 Reset deasserted mid-frame SHALL leave the block in IDLE waiting for data_pri; no stale frame_ready.

Structure
REQ-033 Package ddc_pack_pkg SHALL hold the state enum, the default BANK_AW, and the sample-lane order constants.
REQ-034 A single sub-module, ddc_word_packer (registered 8x16 to 128 packing plus write strobe), is natural; everything else lives in the top.

Verification
REQ-035 Directed scenario: enable=1; data_pri; 100 valid beats with data_1_I=n, others constant; data_pri -> writes at addr 0..99, then frame_ready with data_length=100, rd_bank=0, next writes from addr 0x2000.
REQ-036 Directed scenario: data_pri and data_valid in the same cycle -> that sample is written at offset 0 of the new bank; the previous data_length excludes it.
REQ-037 Directed scenario: 8200 valid beats in one PRI -> 8192 writes (last offset 0x1FFF); close gives data_length=8192, overflow=1; the next frame gives overflow=0.
REQ-038 Directed scenario: data_cpi with data_pri, then 3 more data_pri -> pri_index reports 0,1,2 on successive frame_ready.
REQ-039 Directed scenario: rst_n low mid-capture for 3 cycles -> outputs are 0 asynchronously; no writes until the next data_pri after release.
REQ-040 Directed scenario: enable drops mid-PRI -> no frame_ready, data_length unchanged, state IDLE.
